memoria_ram: RTL and testbench
==============================

Name: memoria_ram

Overview:
Single-port synchronous RAM, 256 words x 8 bits, used as the CPU's program/data memory.
- Writes happen on the rising clock edge when enabled.
- Reads are registered: data_out presents the addressed word one cycle after the address is sampled.
- Synchronous active-low reset clears the output register and the whole array.

Parameters:
- ADDR_W, 8, address width; depth = 2**ADDR_W words.
- DATA_W, 8, word width in bits.

Ports:
- clk  input  1  system clock; all activity on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- wr_en  input  1  write enable; 1 = write data_in at address this edge.
- address  input  ADDR_W  word address for read and write.
- data_in  input  DATA_W  write data.
- data_out  output  DATA_W  registered read data.

Behaviour:
- All state updates on posedge clk only; no asynchronous paths.
- Reset (rst_n=0 at a rising edge):
  - data_out <= 0.
  - Every memory word <= 0. The clear completes in that single edge; no multi-cycle init sequence.
  - Reset has priority over wr_en; a write presented during reset is discarded.
- Write (rst_n=1, wr_en=1):
  - mem[address] <= data_in.
  - data_out <= data_in (write-first / write-through).
- Read (rst_n=1, wr_en=0):
  - data_out <= mem[address].
  - Latency 1 cycle: data_out is valid after the edge that samples address.
- data_out holds its value between edges and changes only at a clock edge.
- The full address range 0..2**ADDR_W-1 is valid. No out-of-range case exists and there is no wrap logic.
- Back-to-back write then read of the same address:
  - The read edge returns the newly written value.
  - A write followed by a read of a different address returns that address's contents.
- X/Z on address while wr_en=1 is a bench error. RTL behaviour in that case is unspecified beyond not corrupting simulation.

Optional Feature:
MEMORIA_RAM_PARITY_EN
- Defined:
  - Each word stores an extra even-parity bit computed from data_in at write time. Reset clears the parity bits to 0, which is consistent with all-zero data.
  - Output port parity_err (1 bit) is added. It is registered alongside data_out: 1 when a read word's stored parity does not match recomputed parity, 0 on writes and after reset.
  - A hierarchical/backdoor flip of a stored bit must raise parity_err on the next read of that word.
- Not defined:
  - No parity storage and no parity_err port.
  - Behaviour is exactly as above.

Decomposition:
- Package memoria_ram_pkg holds:
  - localparams ADDR_W=8 and DATA_W=8.
  - typedefs addr_t (logic [ADDR_W-1:0]) and data_t (logic [DATA_W-1:0]).
  - Function calc_parity(data_t), used only when the macro is defined.
- Single module; no sub-module. The array, output register and parity logic are simple enough to live in one always_ff block plus the parity function.

Test Plan:
- Reset: rst_n=0 for 2 cycles, then read addresses 0, 10 and 255 -> data_out = 8'h00 each, one cycle after the address is applied.
- Basic write/read: write 8'hAB to address 10 for one cycle, then wr_en=0 with address 10 for one cycle -> data_out = 8'hAB. During the write cycle itself, data_out = 8'hAB (write-first).
- Random sweep: 5+ random (address, data) pairs, each a write cycle followed by a read cycle -> data_out matches the written data. Then re-read all written addresses in a different order -> all values still match (no aliasing).
- Boundaries:
  - Write 8'h5A to address 0 and 8'hC3 to address 255, then read 255 and 0 -> data_out = 8'hC3, then 8'h5A.
  - Address 1 is still 8'h00.
- Reset mid-operation: with address 20 holding 8'h77, assert rst_n=0 together with wr_en=1, data_in=8'hFF, address 20 -> afterwards, reading address 20 gives 8'h00 and data_out = 8'h00 during reset.
- Parity (MEMORIA_RAM_PARITY_EN defined only):
  - Write 8'h01 to address 3, then read -> parity_err=0.
  - Force-flip mem[3] bit 0, then read -> parity_err=1 and data_out = 8'h00.

Source files
------------

// File: rtl/memoria_ram_pkg.sv
// Shared widths, types and parity helper for the memoria_ram program/data memory.
// The optional stored-parity feature is enabled with MEMORIA_RAM_PARITY_EN.
package memoria_ram_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic calc_parity(data_t d);
    return ^d;
  endfunction

endpackage

// File: rtl/memoria_ram_if.sv
// Bus bundle between the CPU (master) and memoria_ram (slave).
// parity_err exists only when MEMORIA_RAM_PARITY_EN is defined.
interface memoria_ram_if;
  import memoria_ram_pkg::*;

  logic  wr_en;
  addr_t address;
  data_t data_in;
  data_t data_out;
`ifdef MEMORIA_RAM_PARITY_EN
  logic  parity_err;
`endif

`ifdef MEMORIA_RAM_PARITY_EN
  modport master (output wr_en, address, data_in, input data_out, parity_err);
  modport slave  (input wr_en, address, data_in, output data_out, parity_err);
`else
  modport master (output wr_en, address, data_in, input data_out);
  modport slave  (input wr_en, address, data_in, output data_out);
`endif

endinterface

// File: rtl/memoria_ram.sv
// Single-port 256x8 synchronous RAM, write-first, registered read, full-array sync clear.
// Define MEMORIA_RAM_PARITY_EN to store an even-parity bit per word and flag mismatches on read.
module memoria_ram (
  input  logic          clk,
  input  logic          rst_n,
  memoria_ram_if.slave  bus
);
  import memoria_ram_pkg::*;

  data_t mem [DEPTH];
`ifdef MEMORIA_RAM_PARITY_EN
  logic  par_mem [DEPTH];
`endif

  // Reset clears the whole array in one edge and overrides any write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem          <= '{default: '0};
      bus.data_out <= '0;
`ifdef MEMORIA_RAM_PARITY_EN
      par_mem        <= '{default: 1'b0};
      bus.parity_err <= 1'b0;
`endif
    end else if (bus.wr_en) begin
      mem[bus.address] <= bus.data_in;
      bus.data_out     <= bus.data_in;
`ifdef MEMORIA_RAM_PARITY_EN
      par_mem[bus.address] <= calc_parity(bus.data_in);
      bus.parity_err       <= 1'b0;
`endif
    end else begin
      bus.data_out <= mem[bus.address];
`ifdef MEMORIA_RAM_PARITY_EN
      bus.parity_err <= calc_parity(mem[bus.address]) != par_mem[bus.address];
`endif
    end
  end

endmodule

// File: tb/tb_memoria_ram.sv
// Self-checking bench for memoria_ram: vector table, random sweep and corner sequences,
// with expectations queued at drive time and popped when the output is sampled.
module tb_memoria_ram;
  import memoria_ram_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  memoria_ram_if bus_if ();

  memoria_ram dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct {
    logic  rst_n;
    logic  wr_en;
    addr_t addr;
    data_t din;
    data_t exp;
    string tag;
  } vec_t;

  typedef struct {
    data_t exp;
    string tag;
  } exp_t;

  vec_t  vecs[$];
  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  data_t model [DEPTH];

  task automatic check8(input string tag, input data_t got, input data_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: data_out=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check1(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%b expected=%b at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, queue the expectation, then pop and compare just after the edge.
  task automatic step(input logic r, input logic we, input addr_t a, input data_t d,
                      input data_t exp, input string tag);
    exp_t e;
    rst_n          = r;
    bus_if.wr_en   = we;
    bus_if.address = a;
    bus_if.data_in = d;
    exp_q.push_back('{exp: exp, tag: tag});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: got=0 entries expected>=1");
    end else begin
      e = exp_q.pop_front();
      check8(e.tag, bus_if.data_out, e.exp);
    end
  endtask

  function automatic void add(input logic r, input logic we, input addr_t a, input data_t d,
                              input data_t exp, input string tag);
    vec_t v;
    v.rst_n = r; v.wr_en = we; v.addr = a; v.din = d; v.exp = exp; v.tag = tag;
    vecs.push_back(v);
  endfunction

  addr_t rnd_addr [6];
  data_t rnd_data [6];

  initial begin
    rst_n          = 1'b0;
    bus_if.wr_en   = 1'b0;
    bus_if.address = '0;
    bus_if.data_in = '0;

    add(1'b0, 1'b0, 8'd0,   8'h00, 8'h00, "reset_cyc0");
    add(1'b0, 1'b0, 8'd0,   8'h00, 8'h00, "reset_cyc1");
    add(1'b1, 1'b0, 8'd0,   8'h00, 8'h00, "post_reset_rd0");
    add(1'b1, 1'b0, 8'd10,  8'h00, 8'h00, "post_reset_rd10");
    add(1'b1, 1'b0, 8'd255, 8'h00, 8'h00, "post_reset_rd255");
    add(1'b1, 1'b1, 8'd10,  8'hAB, 8'hAB, "write_first_10");
    add(1'b1, 1'b0, 8'd10,  8'h00, 8'hAB, "read_back_10");
    add(1'b1, 1'b1, 8'd0,   8'h5A, 8'h5A, "write_addr0");
    add(1'b1, 1'b1, 8'd255, 8'hC3, 8'hC3, "write_addr255");
    add(1'b1, 1'b0, 8'd255, 8'h00, 8'hC3, "read_addr255");
    add(1'b1, 1'b0, 8'd0,   8'h00, 8'h5A, "read_addr0");
    add(1'b1, 1'b0, 8'd1,   8'h00, 8'h00, "read_addr1_untouched");
    add(1'b1, 1'b1, 8'd20,  8'h77, 8'h77, "write_addr20");
    add(1'b1, 1'b0, 8'd20,  8'h00, 8'h77, "read_addr20");
    add(1'b0, 1'b1, 8'd20,  8'hFF, 8'h00, "reset_beats_write");
    add(1'b1, 1'b0, 8'd20,  8'h00, 8'h00, "addr20_cleared");
    add(1'b1, 1'b0, 8'd10,  8'h00, 8'h00, "addr10_cleared");
    add(1'b1, 1'b0, 8'd255, 8'h00, 8'h00, "addr255_cleared");

    foreach (vecs[i])
      step(vecs[i].rst_n, vecs[i].wr_en, vecs[i].addr, vecs[i].din, vecs[i].exp, vecs[i].tag);

    // Random sweep on distinct addresses, then re-read in reverse order.
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      logic dup;
      do begin
        rnd_addr[i] = addr_t'($urandom_range(255));
        dup = 1'b0;
        for (int j = 0; j < i; j++) if (rnd_addr[j] == rnd_addr[i]) dup = 1'b1;
      end while (dup);
      rnd_data[i] = data_t'($urandom_range(255));
      model[rnd_addr[i]] = rnd_data[i];
      step(1'b1, 1'b1, rnd_addr[i], rnd_data[i], rnd_data[i], "rnd_write");
      step(1'b1, 1'b0, rnd_addr[i], 8'h00, model[rnd_addr[i]], "rnd_read");
    end
    for (int i = 5; i >= 0; i--)
      step(1'b1, 1'b0, rnd_addr[i], 8'h00, rnd_data[i], "rnd_reread");

    // Output must hold between edges even if the address moves mid-cycle.
    step(1'b1, 1'b1, 8'd7, 8'h3C, 8'h3C, "hold_setup_write");
    step(1'b1, 1'b0, 8'd7, 8'h00, 8'h3C, "hold_setup_read");
    bus_if.address = 8'd200;
    #2;
    check8("hold_between_edges", bus_if.data_out, 8'h3C);
    @(negedge clk);

    // Write to one address then read another returns the other's contents.
    step(1'b1, 1'b1, 8'd8, 8'h99, 8'h99, "wr8");
    step(1'b1, 1'b0, 8'd7, 8'h00, 8'h3C, "rd7_after_wr8");

`ifdef MEMORIA_RAM_PARITY_EN
    step(1'b1, 1'b1, 8'd3, 8'h01, 8'h01, "par_write3");
    step(1'b1, 1'b0, 8'd3, 8'h00, 8'h01, "par_read3");
    check1("parity_err_clean", bus_if.parity_err, 1'b0);
    dut.mem[3] = dut.mem[3] ^ 8'h01;
    step(1'b1, 1'b0, 8'd3, 8'h00, 8'h00, "par_read3_flipped");
    check1("parity_err_flipped", bus_if.parity_err, 1'b1);
    step(1'b1, 1'b1, 8'd3, 8'h05, 8'h05, "par_rewrite3");
    check1("parity_err_on_write", bus_if.parity_err, 1'b0);
`endif

    check1("scoreboard_drained", exp_q.size() == 0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
